axi4lite_mem_slave: RTL and testbench

- AXI4-Lite slave memory that terminates an AXI4Lite bus; the master side drives it through the S modport signals.
- Byte-addressable RAM of 2**ADDR_W bytes, organised as N-byte words.
- Independent read and write paths, one outstanding transaction on each.
- Used as the default endpoint for AXI4-Lite BFM and master testbenches, and as on-chip scratch RAM.

---
 rtl/axi4lite_mem_slave.sv | 160 ++++++++++++++++
 tb/tb_axi4lite_mem_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_mem_slave
//  Description : AXI4-Lite slave backed by a byte-strobed word RAM. The write
//                path uses one-entry AW and W holding slots; the read path
//                returns data one cycle after the AR handshake.
//                Optional macro AXI4LITE_MEM_PROT_EN makes non-secure
//                accesses (PROT[1]=1) fail with SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_mem_slave #(
    parameter int N      = 4,
    parameter int ADDR_W = 10
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             AWVALID,
    output logic             AWREADY,
    input  logic [31:0]      AWADDR,
    input  logic [2:0]       AWPROT,
    input  logic             WVALID,
    output logic             WREADY,
    input  logic [8*N-1:0]   WDATA,
    input  logic [N-1:0]     WSTRB,
    output logic             BVALID,
    input  logic             BREADY,
    output logic [1:0]       BRESP,
    input  logic             ARVALID,
    output logic             ARREADY,
    input  logic [31:0]      ARADDR,
    input  logic [2:0]       ARPROT,
    output logic             RVALID,
    input  logic             RREADY,
    output logic [8*N-1:0]   RDATA,
    output logic [1:0]       RRESP
);

    localparam int          LB     = $clog2(N);
    localparam int          IDX_W  = ADDR_W - LB;
    localparam int          DEPTH  = 2**IDX_W;
    localparam int          DW     = 8*N;
    localparam logic [1:0]  C_OKAY   = 2'b00;
    localparam logic [1:0]  C_SLVERR = 2'b10;

    logic [DW-1:0]    r_mem [DEPTH];

    logic             r_rst_done;
    logic             r_aw_full;
    logic             r_aw_err;
    logic [IDX_W-1:0] r_aw_idx;
    logic             r_w_full;
    logic [DW-1:0]    r_w_data;
    logic [N-1:0]     r_w_strb;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic             r_rvalid;
    logic [DW-1:0]    r_rdata;
    logic [1:0]       r_rresp;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;
    logic             w_commit;
    logic             w_aw_err;
    logic             w_ar_err;
    logic [IDX_W-1:0] w_aw_idx;
    logic [IDX_W-1:0] w_ar_idx;

    assign w_aw_idx = AWADDR[ADDR_W-1:LB];
    assign w_ar_idx = ARADDR[ADDR_W-1:LB];

`ifdef AXI4LITE_MEM_PROT_EN
    assign w_aw_err = ((AWADDR >> ADDR_W) != 32'd0) | AWPROT[1];
    assign w_ar_err = ((ARADDR >> ADDR_W) != 32'd0) | ARPROT[1];
`else
    assign w_aw_err = ((AWADDR >> ADDR_W) != 32'd0);
    assign w_ar_err = ((ARADDR >> ADDR_W) != 32'd0);
`endif

    // Low address bits and most PROT bits carry no meaning for this slave.
    logic w_unused_ok;
    assign w_unused_ok = ^{AWADDR, ARADDR, AWPROT, ARPROT};

    assign AWREADY = r_rst_done & ~r_aw_full;
    assign WREADY  = r_rst_done & ~r_w_full;
    assign ARREADY = r_rst_done & (~r_rvalid | RREADY);
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

    assign w_aw_hs  = AWVALID & AWREADY;
    assign w_w_hs   = WVALID & WREADY;
    assign w_ar_hs  = ARVALID & ARREADY;
    assign w_commit = r_aw_full & r_w_full & (~r_bvalid | BREADY);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rst_done <= 1'b0;
            r_aw_full  <= 1'b0;
            r_aw_err   <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= C_OKAY;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= C_OKAY;
        end else begin
            r_rst_done <= 1'b1;

            // A slot can never be refilled on its commit edge: its READY is low while full.
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= w_aw_idx;
                r_aw_err  <= w_aw_err;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= WDATA;
                r_w_strb <= WSTRB;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= r_aw_err ? C_SLVERR : C_OKAY;
            end else if (BREADY) begin
                r_bvalid <= 1'b0;
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_ar_err ? '0 : r_mem[w_ar_idx];
                r_rresp  <= w_ar_err ? C_SLVERR : C_OKAY;
            end else if (RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Contents survive reset; a read racing a commit sees the old word.
    always_ff @(posedge ACLK) begin
        if (w_commit && !r_aw_err) begin
            for (int i = 0; i < N; i++) begin
                if (r_w_strb[i]) begin
                    r_mem[r_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4lite_mem_slave
//  Description : Directed bench with a transaction-level model of the slave
//                compared every cycle, plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_mem_slave;

    localparam int MEMSZ = 1024;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [1:0]  BRESP;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        RVALID;
    logic        RREADY = 1'b1;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    int checks = 0;
    int failures = 0;

    axi4lite_mem_slave #(.N(4), .ADDR_W(10)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0]  m_mem [MEMSZ];
    bit          m_rst_done, m_aw_p, m_w_p, m_aw_bad, m_bvalid, m_rvalid;
    logic [31:0] m_aw_addr, m_w_data, m_rdata;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_bresp, m_rresp;

    function automatic bit m_bad(input logic [31:0] a, input logic [2:0] p);
        bit b;
        b = (a >= MEMSZ);
`ifdef AXI4LITE_MEM_PROT_EN
        b = b | p[1];
`endif
        return b;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        int base;
        base = int'(a) & ~3;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m_mem[base + i];
        return r;
    endfunction

    // Check outputs against the model, then advance it across the coming edge.
    always @(negedge ACLK) begin
        bit hs_aw, hs_w, hs_ar, commit, exp_arready;
        int base;
        if (!ARESETn) begin
            m_rst_done = 0; m_aw_p = 0; m_w_p = 0; m_bvalid = 0; m_rvalid = 0;
            m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
        end
        exp_arready = m_rst_done && (!m_rvalid || RREADY);
        chk("m_awready", {31'd0, AWREADY}, {31'd0, m_rst_done && !m_aw_p});
        chk("m_wready",  {31'd0, WREADY},  {31'd0, m_rst_done && !m_w_p});
        chk("m_arready", {31'd0, ARREADY}, {31'd0, exp_arready});
        chk("m_bvalid",  {31'd0, BVALID},  {31'd0, m_bvalid});
        chk("m_rvalid",  {31'd0, RVALID},  {31'd0, m_rvalid});
        if (m_bvalid) chk("m_bresp", {30'd0, BRESP}, {30'd0, m_bresp});
        if (m_rvalid) begin
            chk("m_rdata", RDATA, m_rdata);
            chk("m_rresp", {30'd0, RRESP}, {30'd0, m_rresp});
        end
        if (ARESETn) begin
            hs_ar = ARVALID && exp_arready;
            hs_aw = AWVALID && m_rst_done && !m_aw_p;
            hs_w  = WVALID && m_rst_done && !m_w_p;
            if (hs_ar) begin
                m_rvalid = 1;
                if (m_bad(ARADDR, ARPROT)) begin
                    m_rdata = '0; m_rresp = 2'b10;
                end else begin
                    m_rdata = m_read(ARADDR); m_rresp = 2'b00;
                end
            end else if (RREADY) begin
                m_rvalid = 0;
            end
            commit = m_aw_p && m_w_p && (!m_bvalid || BREADY);
            if (commit) begin
                if (!m_aw_bad) begin
                    base = int'(m_aw_addr) & ~3;
                    for (int i = 0; i < 4; i++)
                        if (m_w_strb[i]) m_mem[base + i] = m_w_data[8*i +: 8];
                end
                m_bvalid = 1;
                m_bresp = m_aw_bad ? 2'b10 : 2'b00;
                m_aw_p = 0; m_w_p = 0;
            end else if (BREADY) begin
                m_bvalid = 0;
            end
            if (hs_aw) begin
                m_aw_p = 1; m_aw_addr = AWADDR; m_aw_bad = m_bad(AWADDR, AWPROT);
            end
            if (hs_w) begin
                m_w_p = 1; m_w_data = WDATA; m_w_strb = WSTRB;
            end
            m_rst_done = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK); #1;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
        bit done = 0;
        AWADDR = a; AWPROT = p; AWVALID = 1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge ACLK); done = AWREADY;
            tick();
        end
        AWVALID = 0;
        if (!done) chk("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit done = 0;
        WDATA = d; WSTRB = s; WVALID = 1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge ACLK); done = WREADY;
            tick();
        end
        WVALID = 0;
        if (!done) chk("w_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p);
        fork
            send_aw(a, p);
            send_w(d, s);
        join
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        bit got = 0;
        BREADY = 1; lat = 0; resp = 2'bxx;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge ACLK); lat++;
            if (BVALID) begin got = 1; resp = BRESP; end
        end
        tick();
        if (!got) chk("b_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] p,
                           output logic [31:0] d, output logic [1:0] r, output int lat);
        bit done = 0;
        bit got = 0;
        RREADY = 1; ARADDR = a; ARPROT = p; ARVALID = 1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge ACLK); done = ARREADY;
            tick();
        end
        ARVALID = 0;
        if (!done) chk("ar_timeout", 0, 1);
        lat = 0; d = 'x; r = 'x;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge ACLK); lat++;
            if (RVALID) begin got = 1; d = RDATA; r = RRESP; end
        end
        tick();
        if (!got) chk("r_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          rv;
        logic [31:0] addrs [4];
        addrs = '{32'h10, 32'h0, 32'h7FC, 32'h13};

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", {31'd0, AWREADY}, 0);
        chk("rst_bvalid",  {31'd0, BVALID}, 0);
        chk("rst_rdata",   RDATA, 0);
        ARESETn = 1;
        tick();

        // 1: simultaneous AW/W, then read back
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
        wait_b(r, lat);
        chk("t1_bresp", {30'd0, r}, 0);
        chk("t1_blat", lat, 2);
        do_read(32'h10, 3'b000, d, r, lat);
        chk("t1_rdata", d, 32'hDEADBEEF);
        chk("t1_rresp", {30'd0, r}, 0);
        chk("t1_rlat", lat, 1);

        // 2: W three cycles ahead of AW, partial strobes
        send_w(32'h11223344, 4'b0101);
        repeat (3) begin
            @(negedge ACLK); chk("t2_wready_held", {31'd0, WREADY}, 0);
            tick();
        end
        send_aw(32'h10, 3'b000);
        wait_b(r, lat);
        chk("t2_bresp", {30'd0, r}, 0);
        do_read(32'h10, 3'b000, d, r, lat);
        chk("t2_rdata", d, 32'hDE22BE44);

        // 3: out-of-range accesses
        do_write(32'h0, 32'hCAFEF00D, 4'hF, 3'b000);
        wait_b(r, lat);
        do_write(32'h400, 32'h55555555, 4'hF, 3'b000);
        wait_b(r, lat);
        chk("t3_bresp_oor", {30'd0, r}, 2);
        do_read(32'h0, 3'b000, d, r, lat);
        chk("t3_word0_kept", d, 32'hCAFEF00D);
        do_read(32'h7FC, 3'b000, d, r, lat);
        chk("t3_rdata_oor", d, 0);
        chk("t3_rresp_oor", {30'd0, r}, 2);

        // 4: back-to-back reads, then stalled read channel
        RREADY = 1; ARPROT = 0; ARVALID = 1; rv = 0;
        for (int i = 0; i < 4; i++) begin
            ARADDR = addrs[i];
            @(negedge ACLK);
            chk("t4_b2b_arready", {31'd0, ARREADY}, 1);
            if (RVALID) rv++;
            tick();
        end
        ARVALID = 0;
        @(negedge ACLK); if (RVALID) rv++;
        tick();
        chk("t4_rvalid_cycles", rv, 4);

        RREADY = 0; ARADDR = 32'h0; ARVALID = 1;
        @(negedge ACLK); chk("t4_arready_idle", {31'd0, ARREADY}, 1);
        tick();
        ARADDR = 32'h10;
        repeat (5) begin
            @(negedge ACLK);
            chk("t4_arready_stall", {31'd0, ARREADY}, 0);
            chk("t4_rdata_stable", RDATA, 32'hCAFEF00D);
            tick();
        end
        RREADY = 1;
        @(negedge ACLK); chk("t4_arready_release", {31'd0, ARREADY}, 1);
        tick();
        ARVALID = 0;
        @(negedge ACLK); chk("t4_rdata_next", RDATA, 32'hDE22BE44);
        tick();

        // 5: second pair held in the slots while BREADY is low
        BREADY = 0;
        do_write(32'h500, 32'h1, 4'hF, 3'b000);
        tick();
        @(negedge ACLK);
        chk("t5_bvalid1", {31'd0, BVALID}, 1);
        chk("t5_bresp1", {30'd0, BRESP}, 2);
        tick();
        do_write(32'h20, 32'hA5A5A5A5, 4'hF, 3'b000);
        repeat (3) begin
            @(negedge ACLK);
            chk("t5_bresp_hold", {30'd0, BRESP}, 2);
            chk("t5_awready_full", {31'd0, AWREADY}, 0);
            tick();
        end
        BREADY = 1;
        tick();
        @(negedge ACLK);
        chk("t5_bvalid2", {31'd0, BVALID}, 1);
        chk("t5_bresp2", {30'd0, BRESP}, 0);
        tick();
        @(negedge ACLK); chk("t5_bvalid_clear", {31'd0, BVALID}, 0);
        tick();
        do_read(32'h20, 3'b000, d, r, lat);
        chk("t5_rdata", d, 32'hA5A5A5A5);

        // 6: asynchronous reset with slot full and response pending
        BREADY = 0;
        do_write(32'h30, 32'h0BADC0DE, 4'hF, 3'b000);
        tick();
        send_aw(32'h34, 3'b000);
        chk("t6_pre_bvalid", {31'd0, BVALID}, 1);
        chk("t6_pre_awready", {31'd0, AWREADY}, 0);
        ARESETn = 0;
        #1;
        chk("t6_awready", {31'd0, AWREADY}, 0);
        chk("t6_wready",  {31'd0, WREADY}, 0);
        chk("t6_arready", {31'd0, ARREADY}, 0);
        chk("t6_bvalid",  {31'd0, BVALID}, 0);
        chk("t6_rvalid",  {31'd0, RVALID}, 0);
        chk("t6_bresp",   {30'd0, BRESP}, 0);
        chk("t6_rresp",   {30'd0, RRESP}, 0);
        chk("t6_rdata",   RDATA, 0);
        BREADY = 1;
        repeat (2) tick();
        ARESETn = 1;
        tick();
        do_read(32'h30, 3'b000, d, r, lat);
        chk("t6_persist30", d, 32'h0BADC0DE);
        do_read(32'h10, 3'b000, d, r, lat);
        chk("t6_persist10", d, 32'hDE22BE44);
`ifdef AXI4LITE_MEM_PROT_EN
        do_read(32'h10, 3'b010, d, r, lat);
        chk("t6_prot_rresp", {30'd0, r}, 2);
        chk("t6_prot_rdata", d, 0);
        do_write(32'h10, 32'hFFFFFFFF, 4'hF, 3'b010);
        wait_b(r, lat);
        chk("t6_prot_bresp", {30'd0, r}, 2);
        do_read(32'h10, 3'b000, d, r, lat);
        chk("t6_prot_nowrite", d, 32'hDE22BE44);
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
